// File: rtl/draw_particle_multi_if.sv
// ============================================================================
// Module : vga_if
// Brief  : VGA timing + colour bundle passed between pixel-pipeline stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_if;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_particle_multi.sv
// ============================================================================
// Module : draw_particle_multi
// Brief  : Overlays up to N_PART double-buffered sprites on a VGA stream;
//          optional colour-key transparency with DRAW_PARTICLE_TRANSPARENT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module draw_particle_multi #(
    parameter int N_PART = 4,
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int IDX_W  = (N_PART > 1) ? $clog2(N_PART) : 1,
    parameter int AW     = IDX_W + $clog2(SPR_H) + $clog2(SPR_W)
) (
    input  logic              clk60MHz,
    input  logic              rst,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic [IDX_W-1:0]  pos_idx,
    input  logic [11:0]       pos_x,
    input  logic [11:0]       pos_y,
    input  logic              pos_en,
    output logic [AW-1:0]     pixel_addr,
    input  logic [11:0]       rgb_pixel,
    vga_if.in                 in,
    vga_if.out                out
);

    localparam int C_ROW_W = $clog2(SPR_H);
    localparam int C_COL_W = $clog2(SPR_W);

    // Slot position sets: shadow is written by the host, active feeds drawing
    logic [N_PART-1:0][11:0] r_sh_x;
    logic [N_PART-1:0][11:0] r_sh_y;
    logic [N_PART-1:0]       r_sh_en;
    logic [N_PART-1:0][11:0] r_ac_x;
    logic [N_PART-1:0][11:0] r_ac_y;
    logic [N_PART-1:0]       r_ac_en;
    logic                    r_vblnk_d;

    logic                    w_commit;
    logic                    w_xfer;

    assign w_commit  = in.vblnk & ~r_vblnk_d;
    assign pos_ready = ~rst & ~w_commit;
    assign w_xfer    = pos_valid & pos_ready;

    // r_vblnk_d leaves reset high so a blank already in progress is not a rise
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_sh_en   <= '0;
            r_ac_x    <= '0;
            r_ac_y    <= '0;
            r_ac_en   <= '0;
            r_vblnk_d <= 1'b1;
        end else begin
            r_vblnk_d <= in.vblnk;
            for (int i = 0; i < N_PART; i++) begin
                if (w_commit) begin
                    r_ac_x[i]  <= r_sh_x[i];
                    r_ac_y[i]  <= r_sh_y[i];
                    r_ac_en[i] <= r_sh_en[i];
                end
                if (w_xfer && (pos_idx == IDX_W'(i))) begin
                    r_sh_x[i]  <= pos_x;
                    r_sh_y[i]  <= pos_y;
                    r_sh_en[i] <= pos_en;
                end
            end
        end
    end

    // Stage 0: hit test at 13 bits so sprites near 4095 never wrap to column 0
    logic [12:0]             w_h13;
    logic [12:0]             w_v13;
    logic [N_PART-1:0]       w_hit;

    assign w_h13 = {1'b0, in.hcount};
    assign w_v13 = {1'b0, in.vcount};

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_PART; i++) begin
            w_hit[i] = r_ac_en[i]
                     && (w_h13 >= {1'b0, r_ac_x[i]})
                     && (w_h13 <  ({1'b0, r_ac_x[i]} + 13'(SPR_W)))
                     && (w_v13 >= {1'b0, r_ac_y[i]})
                     && (w_v13 <  ({1'b0, r_ac_y[i]} + 13'(SPR_H)));
        end
    end

    logic                    w_any;
    logic [IDX_W-1:0]        w_win;
    logic [11:0]             w_sel_x;
    logic [11:0]             w_sel_y;
    logic [C_ROW_W-1:0]      w_row;
    logic [C_COL_W-1:0]      w_col;

    // Scan from the top so the lowest-index hit is the one that sticks
    always_comb begin
        w_win   = '0;
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = N_PART - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win   = IDX_W'(i);
                w_sel_x = r_ac_x[i];
                w_sel_y = r_ac_y[i];
            end
        end
    end

    assign w_any      = |w_hit;
    assign w_row      = C_ROW_W'(in.vcount - w_sel_y);
    assign w_col      = C_COL_W'(in.hcount - w_sel_x);
    assign pixel_addr = w_any ? {w_win, w_row, w_col} : '0;

    // Stage 1: align timing with the ROM read
    logic [11:0]             r1_vcount;
    logic                    r1_vsync;
    logic                    r1_vblnk;
    logic [11:0]             r1_hcount;
    logic                    r1_hsync;
    logic                    r1_hblnk;
    logic [11:0]             r1_rgb;
    logic                    r1_hit;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            r1_vcount <= '0;
            r1_vsync  <= 1'b0;
            r1_vblnk  <= 1'b0;
            r1_hcount <= '0;
            r1_hsync  <= 1'b0;
            r1_hblnk  <= 1'b0;
            r1_rgb    <= '0;
            r1_hit    <= 1'b0;
        end else begin
            r1_vcount <= in.vcount;
            r1_vsync  <= in.vsync;
            r1_vblnk  <= in.vblnk;
            r1_hcount <= in.hcount;
            r1_hsync  <= in.hsync;
            r1_hblnk  <= in.hblnk;
            r1_rgb    <= in.rgb;
            r1_hit    <= w_any;
        end
    end

    // Stage 2: colour select
    logic                    w_opaque;
    logic                    w_draw;

`ifdef DRAW_PARTICLE_TRANSPARENT_EN
    assign w_opaque = (rgb_pixel != 12'hF0F);
`else
    assign w_opaque = 1'b1;
`endif

    assign w_draw = r1_hit & ~(r1_hblnk | r1_vblnk) & w_opaque;

    logic [11:0]             r2_vcount;
    logic                    r2_vsync;
    logic                    r2_vblnk;
    logic [11:0]             r2_hcount;
    logic                    r2_hsync;
    logic                    r2_hblnk;
    logic [11:0]             r2_rgb;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            r2_vcount <= '0;
            r2_vsync  <= 1'b0;
            r2_vblnk  <= 1'b0;
            r2_hcount <= '0;
            r2_hsync  <= 1'b0;
            r2_hblnk  <= 1'b0;
            r2_rgb    <= '0;
        end else begin
            r2_vcount <= r1_vcount;
            r2_vsync  <= r1_vsync;
            r2_vblnk  <= r1_vblnk;
            r2_hcount <= r1_hcount;
            r2_hsync  <= r1_hsync;
            r2_hblnk  <= r1_hblnk;
            r2_rgb    <= w_draw ? rgb_pixel : r1_rgb;
        end
    end

    assign out.vcount = r2_vcount;
    assign out.vsync  = r2_vsync;
    assign out.vblnk  = r2_vblnk;
    assign out.hcount = r2_hcount;
    assign out.hsync  = r2_hsync;
    assign out.hblnk  = r2_hblnk;
    assign out.rgb    = r2_rgb;

endmodule

`default_nettype wire
